// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and range-check helper for the up/down counter
//
// Purpose: counter mode enum and the clamp/wrap helper used by the counter's
// next-value logic. The helper works on a fixed 34-bit signed sum (enough
// for WIDTH up to 32 plus carry and sign) so one function serves every width.
// Ports: none (package).

package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  localparam int CNT_MAX_WIDTH = 32;

  typedef struct packed {
    logic [CNT_MAX_WIDTH-1:0] value;
    logic                     ovf;
    logic                     unf;
  } cnt_clamp_t;

  // Range-checks a signed sum against [0, ceil]. In wrap mode the low bits of
  // the two's-complement sum are already the value modulo 2**WIDTH once the
  // caller truncates to WIDTH; in saturate mode the result is pinned.
  function automatic cnt_clamp_t cnt_clamp(
    input logic signed [CNT_MAX_WIDTH+1:0] sum,
    input logic        [CNT_MAX_WIDTH-1:0] ceil,
    input cnt_mode_e                       mode
  );
    cnt_clamp_t r;
    r.ovf   = (sum > $signed({2'b00, ceil}));
    r.unf   = (sum < 34'sd0);
    r.value = sum[CNT_MAX_WIDTH-1:0];
    if (mode == CNT_SAT) begin
      if (r.ovf) begin
        r.value = ceil;
      end else if (r.unf) begin
        r.value = '0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised up/down counter with wrap/saturate and status flags
//
// Purpose: counts up by incr and down by decr (netted in the same cycle), with
// wrap or saturate behaviour, overflow/underflow pulses, sticky status and
// zero/max indicators.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   reinit, initial_value load initial_value on the next edge (also reset value)
//   incr_valid, incr      unsigned increment operand
//   decr_valid, decr      unsigned decrement operand
//   clr_status            clear sticky flags
//   value, value_next     registered count, combinational next count
//   overflow, underflow   one-cycle pulses after an out-of-range update
//   overflow_sticky,
//   underflow_sticky      latched versions of the pulses
//   is_zero, is_max       decoded from the registered count

module updown_counter_param
  import counter_pkg::*;
#(
  parameter int        WIDTH      = 4,
  parameter int        INCR_WIDTH = 2,
  parameter int        DECR_WIDTH = 2,
  parameter cnt_mode_e MODE       = CNT_WRAP,
  parameter longint    MAX_VALUE  = (longint'(1) << WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reinit,
  input  logic [WIDTH-1:0]      initial_value,
  input  logic                  incr_valid,
  input  logic [INCR_WIDTH-1:0] incr,
  input  logic                  decr_valid,
  input  logic [DECR_WIDTH-1:0] decr,
  input  logic                  clr_status,
  output logic [WIDTH-1:0]      value,
  output logic [WIDTH-1:0]      value_next,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  overflow_sticky,
  output logic                  underflow_sticky,
  output logic                  is_zero,
  output logic                  is_max
);

  if (WIDTH < 2 || WIDTH > CNT_MAX_WIDTH) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be in 2..32");
  end
  if (INCR_WIDTH < 1 || INCR_WIDTH > WIDTH || DECR_WIDTH < 1 || DECR_WIDTH > WIDTH) begin : g_bad_opw
    $error("updown_counter_param: INCR_WIDTH/DECR_WIDTH must be in 1..WIDTH");
  end
  if (MAX_VALUE < 0 || MAX_VALUE > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("updown_counter_param: MAX_VALUE does not fit in WIDTH bits");
  end

  // In wrap mode the ceiling is the natural all-ones top of the register.
  localparam logic [WIDTH-1:0] CEIL = (MODE == CNT_SAT) ? WIDTH'(MAX_VALUE) : {WIDTH{1'b1}};

  logic [WIDTH-1:0] value_q, value_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic             unf_sticky_q, unf_sticky_d;

  logic        [WIDTH+1:0] inc_w;
  logic        [WIDTH+1:0] dec_w;
  logic signed [WIDTH+1:0] sum;
  cnt_clamp_t              clamp;

  always_comb begin
    inc_w = '0;
    dec_w = '0;
    if (incr_valid) inc_w = {{(WIDTH+2-INCR_WIDTH){1'b0}}, incr};
    if (decr_valid) dec_w = {{(WIDTH+2-DECR_WIDTH){1'b0}}, decr};
    // Two extra bits hold the carry above the ceiling and the sign below zero,
    // so the range check sees the untruncated net result.
    sum   = $signed({2'b00, value_q}) + $signed(inc_w) - $signed(dec_w);
    clamp = cnt_clamp(34'(sum), 32'(CEIL), MODE);

    value_d     = WIDTH'(clamp.value);
    overflow_d  = clamp.ovf;
    underflow_d = clamp.unf;
    if (reinit) begin
      value_d     = initial_value;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end

    // A new event in the same cycle as a clear keeps the flag set.
    ovf_sticky_d = overflow_d  | (ovf_sticky_q & ~clr_status);
    unf_sticky_d = underflow_d | (unf_sticky_q & ~clr_status);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q      <= initial_value;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
      unf_sticky_q <= 1'b0;
    end else begin
      value_q      <= value_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      ovf_sticky_q <= ovf_sticky_d;
      unf_sticky_q <= unf_sticky_d;
    end
  end

  assign value            = value_q;
  assign value_next       = value_d;
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;
  assign overflow_sticky  = ovf_sticky_q;
  assign underflow_sticky = unf_sticky_q;
  assign is_zero          = (value_q == '0);
  assign is_max           = (value_q == CEIL);

endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - scoreboard bench for updown_counter_param (wrap and saturate instances)

module tb_updown_counter_param;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       reinit = 1'b0;
  logic [3:0] initial_value = 4'd0;
  logic       incr_valid = 1'b0;
  logic [1:0] incr = 2'd0;
  logic       decr_valid = 1'b0;
  logic [1:0] decr = 2'd0;
  logic       clr_status = 1'b0;

  logic [3:0] w_value, w_next, s_value, s_next;
  logic w_ovf, w_unf, w_ovs, w_uns, w_zero, w_max;
  logic s_ovf, s_unf, s_ovs, s_uns, s_zero, s_max;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(4), .INCR_WIDTH(2), .DECR_WIDTH(2), .MODE(CNT_WRAP)) u_wrap (
    .clk(clk), .rst_n(rst_n), .reinit(reinit), .initial_value(initial_value),
    .incr_valid(incr_valid), .incr(incr), .decr_valid(decr_valid), .decr(decr),
    .clr_status(clr_status), .value(w_value), .value_next(w_next),
    .overflow(w_ovf), .underflow(w_unf), .overflow_sticky(w_ovs), .underflow_sticky(w_uns),
    .is_zero(w_zero), .is_max(w_max)
  );

  updown_counter_param #(.WIDTH(4), .INCR_WIDTH(2), .DECR_WIDTH(2), .MODE(CNT_SAT), .MAX_VALUE(10)) u_sat (
    .clk(clk), .rst_n(rst_n), .reinit(reinit), .initial_value(initial_value),
    .incr_valid(incr_valid), .incr(incr), .decr_valid(decr_valid), .decr(decr),
    .clr_status(clr_status), .value(s_value), .value_next(s_next),
    .overflow(s_ovf), .underflow(s_unf), .overflow_sticky(s_ovs), .underflow_sticky(s_uns),
    .is_zero(s_zero), .is_max(s_max)
  );

  typedef struct {
    bit       sel;
    bit       chk_next;
    int       idx;
    logic [3:0] nxt;
    logic [3:0] val;
    bit       ovf, unf, ovs, uns, zero, max;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;

  task automatic check(input string name, input int idx, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s vec%0d: got %0d expected %0d", name, idx, act, expv);
    end
  endtask

  // Stimulus: drive one vector just after a rising edge and queue what the
  // chosen instance must show for value_next now and for the registers after
  // the next edge.
  task automatic apply(input bit sel, input bit rn, input bit ri, input int init,
                       input bit iv, input int inc, input bit dv, input int dec, input bit clr,
                       input bit cn, input int nxt, input int val,
                       input bit ovf, input bit unf, input bit ovs, input bit uns,
                       input bit zero, input bit max);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n         = rn;
    reinit        = ri;
    initial_value = 4'(init);
    incr_valid    = iv;
    incr          = 2'(inc);
    decr_valid    = dv;
    decr          = 2'(dec);
    clr_status    = clr;
    e.sel = sel; e.chk_next = cn; e.idx = pushed;
    e.nxt = 4'(nxt); e.val = 4'(val);
    e.ovf = ovf; e.unf = unf; e.ovs = ovs; e.uns = uns; e.zero = zero; e.max = max;
    exp_q.push_back(e);
    pushed++;
  endtask

  // Monitor: value_next is sampled mid-cycle, registered outputs just after
  // the edge that consumed the vector.
  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        if (me.chk_next)
          check(me.sel ? "sat.value_next" : "wrap.value_next", me.idx, me.sel ? s_next : w_next, me.nxt);
        @(posedge clk);
        #3;
        if (me.sel) begin
          check("sat.value",     me.idx, s_value, me.val);
          check("sat.overflow",  me.idx, s_ovf,   me.ovf);
          check("sat.underflow", me.idx, s_unf,   me.unf);
          check("sat.ovf_stky",  me.idx, s_ovs,   me.ovs);
          check("sat.unf_stky",  me.idx, s_uns,   me.uns);
          check("sat.is_zero",   me.idx, s_zero,  me.zero);
          check("sat.is_max",    me.idx, s_max,   me.max);
        end else begin
          check("wrap.value",     me.idx, w_value, me.val);
          check("wrap.overflow",  me.idx, w_ovf,   me.ovf);
          check("wrap.underflow", me.idx, w_unf,   me.unf);
          check("wrap.ovf_stky",  me.idx, w_ovs,   me.ovs);
          check("wrap.unf_stky",  me.idx, w_uns,   me.uns);
          check("wrap.is_zero",   me.idx, w_zero,  me.zero);
          check("wrap.is_max",    me.idx, w_max,   me.max);
        end
        popped++;
      end
    end
  end

  initial begin
    int budget;
    //     sel rn ri init iv inc dv dec clr cn nxt val ovf unf ovs uns zero max
    // Wrap instance
    apply(0, 0, 0, 5,  0, 0, 0, 0, 0,  0, 0,  5,  0, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 5,  0, 0, 0, 0, 0,  1, 5,  5,  0, 0, 0, 0, 0, 0);
    apply(0, 1, 1, 14, 0, 0, 0, 0, 0,  1, 14, 14, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 14, 1, 3, 0, 0, 0,  1, 1,  1,  1, 0, 1, 0, 0, 0);
    apply(0, 1, 0, 14, 0, 0, 0, 0, 0,  1, 1,  1,  0, 0, 1, 0, 0, 0);
    apply(0, 1, 1, 7,  0, 0, 0, 0, 0,  1, 7,  7,  0, 0, 1, 0, 0, 0);
    apply(0, 1, 0, 7,  1, 3, 1, 2, 0,  1, 8,  8,  0, 0, 1, 0, 0, 0);
    apply(0, 1, 0, 7,  1, 2, 1, 2, 0,  1, 8,  8,  0, 0, 1, 0, 0, 0);
    apply(0, 1, 1, 3,  0, 0, 0, 0, 0,  1, 3,  3,  0, 0, 1, 0, 0, 0);
    apply(0, 1, 1, 12, 1, 3, 0, 0, 0,  1, 12, 12, 0, 0, 1, 0, 0, 0);
    apply(0, 0, 1, 4,  1, 3, 0, 0, 0,  0, 0,  4,  0, 0, 0, 0, 0, 0);
    apply(0, 1, 1, 1,  0, 0, 0, 0, 0,  1, 1,  1,  0, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 1,  0, 0, 1, 3, 0,  1, 14, 14, 0, 1, 0, 1, 0, 0);
    apply(0, 1, 1, 15, 0, 0, 0, 0, 0,  1, 15, 15, 0, 0, 0, 1, 0, 1);
    apply(0, 1, 0, 15, 1, 1, 0, 0, 0,  1, 0,  0,  1, 0, 1, 1, 1, 0);
    apply(0, 1, 0, 15, 0, 0, 1, 1, 1,  1, 15, 15, 0, 1, 0, 1, 0, 1);
    apply(0, 1, 0, 15, 1, 2, 0, 0, 1,  1, 1,  1,  1, 0, 1, 0, 0, 0);
    apply(0, 1, 0, 15, 0, 0, 0, 0, 1,  1, 1,  1,  0, 0, 0, 0, 0, 0);
    // Saturating instance, ceiling 10
    apply(1, 0, 0, 9,  0, 0, 0, 0, 0,  0, 0,  9,  0, 0, 0, 0, 0, 0);
    apply(1, 1, 0, 9,  1, 3, 0, 0, 0,  1, 10, 10, 1, 0, 1, 0, 0, 1);
    apply(1, 1, 0, 9,  0, 0, 0, 0, 0,  1, 10, 10, 0, 0, 1, 0, 0, 1);
    apply(1, 1, 1, 1,  0, 0, 0, 0, 0,  1, 1,  1,  0, 0, 1, 0, 0, 0);
    apply(1, 1, 0, 1,  0, 0, 1, 3, 0,  1, 0,  0,  0, 1, 1, 1, 1, 0);
    apply(1, 1, 0, 1,  0, 0, 1, 1, 0,  1, 0,  0,  0, 1, 1, 1, 1, 0);
    apply(1, 1, 1, 13, 0, 0, 0, 0, 0,  1, 13, 13, 0, 0, 1, 1, 0, 0);
    apply(1, 1, 0, 13, 0, 0, 0, 0, 0,  1, 10, 10, 1, 0, 1, 1, 0, 1);
    apply(1, 1, 0, 13, 1, 3, 1, 3, 0,  1, 10, 10, 0, 0, 1, 1, 0, 1);
    apply(1, 1, 0, 13, 0, 3, 0, 0, 0,  1, 10, 10, 0, 0, 1, 1, 0, 1);
    apply(1, 1, 0, 13, 1, 1, 0, 0, 1,  1, 10, 10, 1, 0, 1, 0, 0, 1);
    apply(1, 1, 0, 13, 0, 0, 0, 0, 1,  1, 10, 10, 0, 0, 0, 0, 0, 1);

    budget = 20;
    while (popped < pushed && budget > 0) begin
      @(posedge clk);
      #5;
      budget--;
    end
    checks++;
    if (popped != pushed) begin
      errors++;
      $display("FAIL drain: got %0d vectors checked expected %0d", popped, pushed);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
